// File: rtl/demux_serial_driver.sv
// Serializer feeding the 1-to-4 demux: accepts a parallel word plus channel,
// shifts it out MSB-first on a while holding s, then idles for GAP cycles.
module demux_serial_driver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_chan,
  input  logic             in_auto,
  output logic             a,
  output logic [1:0]       s,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam logic [5:0] LAST_BIT = 6'(WIDTH - 1);
  // Second-to-last bit index; unreachable sentinel when WIDTH==1
  localparam logic [5:0] PEN_BIT  = (WIDTH > 1) ? 6'(WIDTH - 2) : 6'h3F;
  localparam logic [3:0] LAST_GAP = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic       HAS_GAP  = (GAP > 0);
  localparam logic       ONE_BIT  = (WIDTH == 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shifted;
  logic [5:0]       bit_cnt, bit_cnt_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic [1:0]       rr_ptr, rr_ptr_n;
  logic             a_n, frame_n, done_n, busy_n;
  logic [1:0]       s_n;

  assign in_ready = (state == S_IDLE) && rst_n;
  assign shifted  = shreg << 1;

  // Next-state and next-output computation; outputs are registered below
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    rr_ptr_n  = rr_ptr;
    a_n       = 1'b0;
    s_n       = s;
    frame_n   = 1'b0;
    done_n    = 1'b0;
    busy_n    = busy;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (in_valid && in_ready) begin
          s_n       = in_auto ? rr_ptr : in_chan;
          shreg_n   = in_data;
          a_n       = in_data[WIDTH-1];
          frame_n   = 1'b1;
          done_n    = ONE_BIT;
          bit_cnt_n = '0;
          busy_n    = 1'b1;
          state_n   = S_SHIFT;
          if (in_auto) rr_ptr_n = rr_ptr + 2'd1;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          busy_n    = HAS_GAP;
          gap_cnt_n = '0;
          state_n   = HAS_GAP ? S_GAP : S_IDLE;
        end else begin
          shreg_n   = shifted;
          a_n       = shifted[WIDTH-1];
          bit_cnt_n = bit_cnt + 6'd1;
          done_n    = (bit_cnt == PEN_BIT);
          busy_n    = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == LAST_GAP) begin
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 4'd1;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rr_ptr  <= '0;
      a       <= 1'b0;
      s       <= '0;
      frame   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      rr_ptr  <= rr_ptr_n;
      a       <= a_n;
      s       <= s_n;
      frame   <= frame_n;
      done    <= done_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_demux_serial_driver.sv
// Directed bench: an 8-bit/GAP=1 instance and a 1-bit/GAP=0 instance.
module tb_demux_serial_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  // Instance 1: WIDTH=8, GAP=1
  logic       in_valid, in_ready, in_auto, a, frame, done, busy;
  logic [7:0] in_data;
  logic [1:0] in_chan, s;

  // Instance 2: WIDTH=1, GAP=0
  logic       in_valid2, in_ready2, in_auto2, a2, frame2, done2, busy2;
  logic [0:0] in_data2;
  logic [1:0] in_chan2, s2;

  always #5 clk = ~clk;

  demux_serial_driver #(.WIDTH(8), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chan(in_chan), .in_auto(in_auto),
    .a(a), .s(s), .frame(frame), .done(done), .busy(busy)
  );

  demux_serial_driver #(.WIDTH(1), .GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_chan(in_chan2), .in_auto(in_auto2),
    .a(a2), .s(s2), .frame(frame2), .done(done2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Send one word on instance 1 from an IDLE cycle and check every cycle of
  // the word, its gap cycle and the following IDLE cycle.
  task automatic send(input logic [7:0] data, input logic [1:0] chan, input logic auto_m,
                      input logic [1:0] exp_s, input logic hold, input logic change);
    logic [7:0] exp_bits;
    exp_bits = data;
    check("idle_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = data;
    in_chan  = chan;
    in_auto  = auto_m;
    tick();
    if (!hold) in_valid = 1'b0;
    if (change) begin
      in_data = ~data;
      in_chan = chan - 2'd1;
      in_auto = ~auto_m;
    end
    for (int k = 0; k < 8; k++) begin
      check("a", a, exp_bits[7-k]);
      check("s", s, exp_s);
      check("frame", frame, k == 0);
      check("done", done, k == 7);
      check("busy", busy, 1'b1);
      check("ready_shift", in_ready, 1'b0);
      tick();
    end
    check("gap_a", a, 1'b0);
    check("gap_s", s, exp_s);
    check("gap_busy", busy, 1'b1);
    check("gap_ready", in_ready, 1'b0);
    check("gap_done", done, 1'b0);
    tick();
    check("post_busy", busy, 1'b0);
    check("post_a", a, 1'b0);
    check("post_s_hold", s, exp_s);
  endtask

  initial begin
    in_valid  = 1'b0; in_data  = '0; in_chan  = '0; in_auto  = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; in_chan2 = '0; in_auto2 = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_ready", in_ready, 1'b0);
    check("rst_a", a, 1'b0);
    check("rst_s", s, 2'd0);
    check("rst_frame", frame, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;

    // Single explicit word A5 on channel 2
    send(8'hA5, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0);

    // Round robin with in_valid held high: 0,1,2,3 then wrap to 0
    for (int w = 0; w < 5; w++) send(8'hFF, 2'd3, 1'b1, 2'(w % 4), 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();

    // Mixed mode: auto, explicit 3, auto -> 0,3,1
    do_reset();
    send(8'h3C, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    send(8'hC3, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0);
    send(8'h81, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);

    // Input changes mid-word are ignored
    send(8'h0F, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1);

    // Reset at bit 4 of an auto word
    do_reset();
    in_valid = 1'b1; in_data = 8'hFF; in_auto = 1'b1; in_chan = 2'd2;
    tick();
    in_valid = 1'b0;
    check("pre_rst_s", s, 2'd0);
    for (int k = 0; k < 4; k++) tick();
    check("bit4_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_low_ready", in_ready, 1'b0);
    tick();
    check("abort_a", a, 1'b0);
    check("abort_s", s, 2'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_frame", frame, 1'b0);
    rst_n = 1'b1;
    #1;
    check("release_ready", in_ready, 1'b1);
    send(8'h5A, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);

    // WIDTH=1, GAP=0: one word every 2 cycles, frame and done together
    in_valid2 = 1'b1; in_data2 = 1'b1; in_chan2 = 2'd1; in_auto2 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check("w1_idle_ready", in_ready2, 1'b1);
      check("w1_idle_a", a2, 1'b0);
      tick();
      check("w1_a", a2, 1'b1);
      check("w1_frame", frame2, 1'b1);
      check("w1_done", done2, 1'b1);
      check("w1_busy", busy2, 1'b1);
      check("w1_s", s2, 2'd1);
      check("w1_ready", in_ready2, 1'b0);
      tick();
      check("w1_post_frame", frame2, 1'b0);
      check("w1_post_done", done2, 1'b0);
      check("w1_post_busy", busy2, 1'b0);
    end
    in_valid2 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
